// File: rtl/prim_util_pkg_u.sv
// Shared elaboration-time helpers for the UART primitive set.
package prim_util_pkg_u;

   // Number of bits needed to index 'value' items (never less than 1).
   function automatic int vbits(input int value);
      return (value <= 1) ? 1 : $clog2(value);
   endfunction

   // Elaboration-time ceiling division; prim_seq_div_u is its run-time twin.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/prim_seq_div_u.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Produces floor or ceiling quotient plus the floor remainder behind a
// valid/ready handshake on both sides.
module prim_seq_div_u
   import prim_util_pkg_u::*;
#(
   parameter int Width = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [Width-1:0] dividend_i,
   input  logic [Width-1:0] divisor_i,
   input  logic             ceil_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [Width-1:0] quotient_o,
   output logic [Width-1:0] remainder_o,
   output logic             div_by_zero_o
);

   localparam int CntW = vbits(Width);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           r_state;
   state_e           w_state_next;

   // r_work starts as the dividend; each CALC cycle its MSB is consumed
   // and the new quotient bit enters at the LSB, so it ends as the quotient.
   logic [Width-1:0] r_work;
   logic [Width-1:0] r_divisor;
   logic [Width-1:0] r_rem;
   logic [CntW-1:0]  r_cnt;
   logic             r_ceil;
   logic             r_dz;

   logic [Width-1:0] r_quot_o;
   logic [Width-1:0] r_rem_o;
   logic             r_dz_o;

   logic [Width:0]   w_trial;
   logic             w_ge;
   logic [Width-1:0] w_rem_next;
   logic [Width-1:0] w_q_next;
   logic             w_round_up;
   logic             w_last;

   // One restoring step: shift in the next dividend bit and trial-subtract.
   always_comb begin
      w_trial    = {r_rem, r_work[Width-1]};
      w_ge       = (w_trial >= {1'b0, r_divisor});
      // When the subtraction happens the result is below the divisor, so
      // the low Width bits of the difference are exact.
      w_rem_next = w_ge ? (w_trial[Width-1:0] - r_divisor) : w_trial[Width-1:0];
      w_q_next   = {r_work[Width-2:0], w_ge};
      // A nonzero remainder implies divisor >= 2, so +1 cannot overflow.
      w_round_up = r_ceil && (w_rem_next != '0);
      w_last     = (r_cnt == '0);
   end

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state decode; clear_i overrides every transition.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         IDLE:    if (in_valid_i) w_state_next = CALC;
         CALC:    if (w_last) w_state_next = DONE;
         DONE:    if (out_ready_i) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      if (clear_i) begin
         w_state_next = IDLE;
      end
   end

   // Operand capture, iteration datapath and result registers.
   // A zero divisor still spends one CALC cycle (counter preloaded to 0),
   // so its result appears one cycle after acceptance and is substituted
   // in the same final write that normally commits the quotient.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_work    <= '0;
         r_divisor <= '0;
         r_rem     <= '0;
         r_cnt     <= '0;
         r_ceil    <= 1'b0;
         r_dz      <= 1'b0;
         r_quot_o  <= '0;
         r_rem_o   <= '0;
         r_dz_o    <= 1'b0;
      end else if (clear_i) begin
         r_quot_o  <= '0;
         r_rem_o   <= '0;
         r_dz_o    <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid_i) begin
                  r_work    <= dividend_i;
                  r_divisor <= divisor_i;
                  r_ceil    <= ceil_i;
                  r_dz      <= (divisor_i == '0);
                  r_rem     <= '0;
                  r_cnt     <= (divisor_i == '0) ? '0 : CntW'(Width - 1);
               end
            end
            CALC: begin
               r_work <= w_q_next;
               r_rem  <= w_rem_next;
               r_cnt  <= r_cnt - 1'b1;
               if (w_last) begin
                  if (r_dz) begin
                     r_quot_o <= '1;
                     r_rem_o  <= r_work;
                  end else begin
                     r_quot_o <= w_q_next + {{(Width-1){1'b0}}, w_round_up};
                     r_rem_o  <= w_rem_next;
                  end
                  r_dz_o <= r_dz;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready_o    = (r_state == IDLE);
   assign out_valid_o   = (r_state == DONE);
   assign quotient_o    = r_quot_o;
   assign remainder_o   = r_rem_o;
   assign div_by_zero_o = r_dz_o;

endmodule

// File: tb/tb_prim_seq_div_u.sv
// Self-checking bench for prim_seq_div_u: a 32-bit and an 8-bit instance,
// a scoreboard fed on every accepted request and drained on every result.
module tb_prim_seq_div_u;

   typedef struct {
      logic [63:0] q;
      logic [63:0] r;
      logic        dz;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit instance signals
   logic        clr32 = 0, iv32 = 0, c32 = 0, ordy32 = 1;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ir32, ov32, dz32;
   logic [31:0] q32, r32;
   // 8-bit instance signals
   logic        clr8 = 0, iv8 = 0, c8 = 0, ordy8 = 1;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ir8, ov8, dz8;
   logic [7:0]  q8, r8;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   exp_t sb32[$];
   exp_t sb8[$];
   int acc32[$];
   int acc8[$];

   prim_seq_div_u #(.Width(32)) u_dut32 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr32),
      .in_valid_i(iv32), .in_ready_o(ir32),
      .dividend_i(a32), .divisor_i(b32), .ceil_i(c32),
      .out_valid_o(ov32), .out_ready_i(ordy32),
      .quotient_o(q32), .remainder_o(r32), .div_by_zero_o(dz32)
   );

   prim_seq_div_u #(.Width(8)) u_dut8 (
      .clk_i(clk), .rst_ni(rst_n), .clear_i(clr8),
      .in_valid_i(iv8), .in_ready_o(ir8),
      .dividend_i(a8), .divisor_i(b8), .ceil_i(c8),
      .out_valid_o(ov8), .out_ready_i(ordy8),
      .quotient_o(q8), .remainder_o(r8), .div_by_zero_o(dz8)
   );

   // Reference arithmetic for a w-bit divider.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                  input logic c, input int w);
      exp_t e;
      logic [63:0] mask;
      mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
      if (b == 0) begin
         e.q = mask; e.r = a; e.dz = 1'b1;
      end else begin
         e.q = a / b; e.r = a % b; e.dz = 1'b0;
         if (c && e.r != 0) e.q = e.q + 1;
      end
      return e;
   endfunction

   always @(posedge clk) cyc++;

   // Scoreboard: push on accepted request, pop and compare on delivered result.
   always @(negedge clk) begin : sb_mon
      exp_t e;
      if (rst_n && !clr32 && iv32 && ir32) begin
         sb32.push_back(model({32'd0, a32}, {32'd0, b32}, c32, 32));
         acc32.push_back(cyc);
      end
      if (rst_n && !clr8 && iv8 && ir8) begin
         sb8.push_back(model({56'd0, a8}, {56'd0, b8}, c8, 8));
         acc8.push_back(cyc);
      end
      if (rst_n && !clr32 && ov32 && ordy32) begin
         checks++;
         if (sb32.size() == 0) begin
            failures++;
            $display("FAIL sb32_unexpected q=%0d r=%0d dz=%0b required no result", q32, r32, dz32);
         end else begin
            e = sb32.pop_front();
            if ({32'd0, q32} !== e.q || {32'd0, r32} !== e.r || dz32 !== e.dz) begin
               failures++;
               $display("FAIL sb32_result got q=%0h r=%0h dz=%0b exp q=%0h r=%0h dz=%0b",
                        q32, r32, dz32, e.q, e.r, e.dz);
            end else begin
               $display("sb32 result q=%0h r=%0h dz=%0b ok", q32, r32, dz32);
            end
         end
      end
      if (rst_n && !clr8 && ov8 && ordy8) begin
         checks++;
         if (sb8.size() == 0) begin
            failures++;
            $display("FAIL sb8_unexpected q=%0d r=%0d dz=%0b required no result", q8, r8, dz8);
         end else begin
            e = sb8.pop_front();
            if ({56'd0, q8} !== e.q || {56'd0, r8} !== e.r || dz8 !== e.dz) begin
               failures++;
               $display("FAIL sb8_result got q=%0h r=%0h dz=%0b exp q=%0h r=%0h dz=%0b",
                        q8, r8, dz8, e.q, e.r, e.dz);
            end else begin
               $display("sb8 result q=%0h r=%0h dz=%0b ok", q8, r8, dz8);
            end
         end
      end
   end

   task automatic drive(input bit sel, input logic iv, input logic [63:0] a,
                        input logic [63:0] b, input logic c);
      if (sel) begin iv8 = iv; a8 = a[7:0]; b8 = b[7:0]; c8 = c; end
      else begin iv32 = iv; a32 = a[31:0]; b32 = b[31:0]; c32 = c; end
   endtask

   function automatic logic get_ir(input bit sel);
      return sel ? ir8 : ir32;
   endfunction

   function automatic logic get_ov(input bit sel);
      return sel ? ov8 : ov32;
   endfunction

   // Present a request and return just after its accepting edge.
   task automatic start(input bit sel, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input string nm);
      bit ok = 0;
      drive(sel, 1'b1, a, b, c);
      for (int i = 0; i < 200; i++) begin
         if (get_ir(sel)) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      if (!ok) begin
         checks++; failures++;
         $display("FAIL %s_accept_timeout in_ready stayed 0 required 1", nm);
      end
      @(posedge clk); #1;
      drive(sel, 1'b0, a, b, c);
   endtask

   // Full request with latency check; the scoreboard checks the values.
   task automatic issue(input bit sel, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input int lat_exp, input string nm);
      int lat = -1;
      start(sel, a, b, c, nm);
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (get_ov(sel)) begin lat = i; break; end
      end
      checks++;
      if (lat !== lat_exp) begin
         failures++;
         $display("FAIL %s_latency got %0d required %0d", nm, lat, lat_exp);
      end else begin
         $display("%s %0d/%0d ceil=%0b latency %0d", nm, a, b, c, lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      checks++;
      if ({ir32, ov32, q32, r32, dz32} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset32 got ir=%0b ov=%0b q=%0h r=%0h dz=%0b required 1 0 0 0 0",
                  ir32, ov32, q32, r32, dz32);
      end
      checks++;
      if ({ir8, ov8, q8, r8, dz8} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset8 got ir=%0b ov=%0b q=%0h r=%0h dz=%0b required 1 0 0 0 0",
                  ir8, ov8, q8, r8, dz8);
      end
      $display("reset state checked");
   endtask

   task automatic test_floor();
      issue(0, 100, 7, 0, 32, "floor_100_7");
      issue(0, 64'hFFFF_FFFF, 64'h10, 0, 32, "floor_max_16");
   endtask

   task automatic test_ceil();
      issue(0, 100, 7, 1, 32, "ceil_100_7");
      issue(0, 96, 8, 1, 32, "ceil_96_8");
   endtask

   task automatic test_div_zero();
      issue(0, 55, 0, 0, 1, "dz_55_0");
      issue(1, 9, 0, 1, 1, "dz8_9_0");
   endtask

   task automatic test_edge8();
      issue(1, 255, 1, 1, 8, "e8_255_1");
      issue(1, 0, 5, 0, 8, "e8_0_5");
      issue(1, 5, 255, 1, 8, "e8_5_255");
      issue(1, 200, 13, 1, 8, "e8_200_13");
   endtask

   task automatic test_backpressure();
      logic [31:0] q_hold, r_hold;
      int n_acc;
      bit ok = 0;
      ordy32 = 0;
      start(0, 200, 9, 0, "bp_first");
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (ov32) begin ok = 1; break; end
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL bp_valid_timeout out_valid 0 required 1");
      end
      q_hold = q32; r_hold = r32;
      n_acc = acc32.size();
      drive(0, 1'b1, 20, 4, 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (ov32 !== 1'b1 || ir32 !== 1'b0 || q32 !== q_hold || r32 !== r_hold
             || acc32.size() != n_acc) begin
            failures++;
            $display("FAIL bp_hold cyc%0d got ov=%0b ir=%0b q=%0h r=%0h acc=%0d required 1 0 %0h %0h %0d",
                     i, ov32, ir32, q32, r32, acc32.size(), q_hold, r_hold, n_acc);
         end
      end
      $display("backpressure held 10 cycles q=%0d r=%0d", q_hold, r_hold);
      ordy32 = 1;
      @(posedge clk); #1;
      checks++;
      if (ir32 !== 1'b1) begin
         failures++;
         $display("FAIL bp_release_idle got in_ready=%0b required 1", ir32);
      end
      @(posedge clk); #1;
      drive(0, 1'b0, 20, 4, 0);
      checks++;
      if (acc32.size() != n_acc + 1) begin
         failures++;
         $display("FAIL bp_new_accept got accepts=%0d required %0d", acc32.size(), n_acc + 1);
      end
      drain();
   endtask

   task automatic drain();
      bit ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (sb32.size() == 0 && sb8.size() == 0 && ir32 && ir8) begin ok = 1; break; end
         @(posedge clk); #1;
      end
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL drain_timeout pending32=%0d pending8=%0d required 0", sb32.size(), sb8.size());
      end
   endtask

   task automatic test_clear();
      bit seen = 0;
      start(0, 1000, 3, 0, "clr_calc");
      repeat (9) @(posedge clk);
      #1; clr32 = 1;
      @(posedge clk); #1; clr32 = 0;
      checks++;
      if (ir32 !== 1'b1 || ov32 !== 1'b0 || q32 !== 32'd0 || r32 !== 32'd0) begin
         failures++;
         $display("FAIL clear_calc got ir=%0b ov=%0b q=%0h r=%0h required 1 0 0 0", ir32, ov32, q32, r32);
      end
      sb32.delete();
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (ov32) seen = 1;
      end
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL clear_no_result got out_valid=1 required 0");
      end
      // A handshake in the same cycle as clear must be ignored.
      drive(0, 1'b1, 100, 7, 0);
      clr32 = 1;
      @(posedge clk); #1;
      clr32 = 0;
      drive(0, 1'b0, 100, 7, 0);
      checks++;
      if (ir32 !== 1'b1) begin
         failures++;
         $display("FAIL clear_handshake got in_ready=%0b required 1", ir32);
      end
      $display("clear aborts checked");
   endtask

   task automatic test_reset_mid();
      issue(0, 100, 7, 0, 32, "pre_rst");
      start(0, 1000, 3, 1, "rst_calc");
      repeat (5) @(posedge clk);
      #2; rst_n = 0;
      #1;
      checks++;
      if ({ir32, ov32, q32, r32, dz32} !== {1'b1, 1'b0, 32'd0, 32'd0, 1'b0}) begin
         failures++;
         $display("FAIL reset_mid got ir=%0b ov=%0b q=%0h r=%0h dz=%0b required 1 0 0 0 0",
                  ir32, ov32, q32, r32, dz32);
      end
      sb32.delete(); sb8.delete();
      @(posedge clk); #1; rst_n = 1;
      @(posedge clk); #1;
      issue(0, 100, 7, 0, 32, "post_rst");
   endtask

   task automatic test_back_to_back();
      int base = acc32.size();
      bit ok = 0;
      int d;
      drive(0, 1'b1, 100, 7, 0);
      for (int i = 0; i < 200; i++) begin
         @(posedge clk); #1;
         if (acc32.size() >= base + 2) begin ok = 1; break; end
      end
      drive(0, 1'b0, 100, 7, 0);
      d = ok ? acc32[base + 1] - acc32[base] : -1;
      checks++;
      if (d !== 34) begin
         failures++;
         $display("FAIL b2b_period got %0d required 34", d);
      end else $display("b2b normal period %0d", d);
      drain();
      base = acc32.size(); ok = 0;
      drive(0, 1'b1, 55, 0, 0);
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (acc32.size() >= base + 2) begin ok = 1; break; end
      end
      drive(0, 1'b0, 55, 0, 0);
      d = ok ? acc32[base + 1] - acc32[base] : -1;
      checks++;
      if (d !== 3) begin
         failures++;
         $display("FAIL b2b_dz_period got %0d required 3", d);
      end else $display("b2b div-by-zero period %0d", d);
      drain();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1;
      @(posedge clk); #1;
      test_floor();
      test_ceil();
      test_div_zero();
      test_edge8();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_back_to_back();
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
